// File: rtl/milano_pkg.sv
// Shared milano core definitions: load/store type codes, LSU FSM states,
// and the access-size decode used on both the store and the load path.
package milano_pkg;

   typedef enum logic [2:0] {
      LSU_LW  = 3'b000,
      LSU_LH  = 3'b001,
      LSU_LB  = 3'b010,
      LSU_LHU = 3'b101,
      LSU_LBU = 3'b110
   } lsu_type_e;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_WORD,
      SZ_HALF,
      SZ_BYTE
   } lsu_size_e;

   // Size code 11 (types 011/111) and the unsigned-word code 100 fall back to word.
   function automatic lsu_size_e lsu_size(input logic [2:0] t);
      case (t[1:0])
         2'b01:   return SZ_HALF;
         2'b10:   return SZ_BYTE;
         default: return SZ_WORD;
      endcase
   endfunction

   function automatic logic lsu_misaligned(input logic [2:0] t, input logic [1:0] off);
      case (lsu_size(t))
         SZ_HALF: return off[0];
         SZ_WORD: return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/milano_lsu_align.sv
// Lane steering for the LSU: store byte enables / replicated write data, and
// load data shift plus sign/zero extension. Purely combinational.
module milano_lsu_align
   import milano_pkg::*;
(
   input  logic [1:0]  st_off,
   input  logic [2:0]  st_type,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [1:0]  ld_off,
   input  logic [2:0]  ld_type,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);

   logic [1:0]  ld_eff;
   logic [31:0] ld_shift;
   logic        ld_sext;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (lsu_size(st_type))
         SZ_BYTE: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Halves only honour addr[1] and words ignore both low bits, so the
   // shift is derived from the size-masked offset rather than the raw one.
   always_comb begin
      ld_sext   = ~ld_type[2];
      ld_eff    = 2'b00;
      case (lsu_size(ld_type))
         SZ_BYTE: ld_eff = ld_off;
         SZ_HALF: ld_eff = {ld_off[1], 1'b0};
         default: ld_eff = 2'b00;
      endcase
      ld_shift  = ld_rdata >> {ld_eff, 3'b000};
      ld_result = ld_shift;
      case (lsu_size(ld_type))
         SZ_BYTE: ld_result = {{24{ld_sext & ld_shift[7]}}, ld_shift[7:0]};
         SZ_HALF: ld_result = {{16{ld_sext & ld_shift[15]}}, ld_shift[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/milano_lsu.sv
// milano load/store unit: one outstanding req/gnt/rvalid bus transaction,
// aligned load writeback. Define MILANO_LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module milano_lsu
   import milano_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              lsu_req_i,
   input  logic              lsu_we_i,
   input  logic [2:0]        lsu_type_i,
   input  logic [31:0]       operand_a_i,
   input  logic [31:0]       operand_b_i,
   input  logic [31:0]       wdata_i,
   input  logic [4:0]        rd_addr_i,
   output logic              busy_o,
   output logic              data_req_o,
   input  logic              data_gnt_i,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [31:0]       data_wdata_o,
   input  logic              data_rvalid_i,
   input  logic [31:0]       data_rdata_i,
   input  logic              data_err_i,
   output logic              wb_en_o,
   output logic [4:0]        wb_addr_o,
   output logic [31:0]       wb_data_o,
   output logic              lsu_err_o
);

   lsu_state_e  state_q;
   logic [31:0] ea;
   logic [1:0]  off_q;
   logic [2:0]  type_q;
   logic [4:0]  rd_q;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_result;
   logic        misalign;

   assign ea = operand_a_i + operand_b_i;

`ifdef MILANO_LSU_MISALIGN_TRAP_EN
   assign misalign = lsu_misaligned(lsu_type_i, ea[1:0]);
`else
   assign misalign = 1'b0;
`endif

   assign busy_o = lsu_req_i | (state_q != IDLE);

   milano_lsu_align u_align (
      .st_off    (ea[1:0]),
      .st_type   (lsu_type_i),
      .st_data   (wdata_i),
      .st_be     (st_be),
      .st_wdata  (st_wdata),
      .ld_off    (off_q),
      .ld_type   (type_q),
      .ld_rdata  (data_rdata_i),
      .ld_result (ld_result)
   );

   // data_we_o doubles as the captured store flag for the completion decision.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         data_req_o   <= 1'b0;
         data_addr_o  <= '0;
         data_we_o    <= 1'b0;
         data_be_o    <= '0;
         data_wdata_o <= '0;
         wb_en_o      <= 1'b0;
         wb_addr_o    <= '0;
         wb_data_o    <= '0;
         lsu_err_o    <= 1'b0;
         off_q        <= '0;
         type_q       <= '0;
         rd_q         <= '0;
      end else begin
         wb_en_o   <= 1'b0;
         lsu_err_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (lsu_req_i) begin
                  if (misalign) begin
                     lsu_err_o <= 1'b1;
                  end else begin
                     state_q      <= REQ;
                     data_req_o   <= 1'b1;
                     data_addr_o  <= ADDR_W'({ea[31:2], 2'b00});
                     data_we_o    <= lsu_we_i;
                     data_be_o    <= st_be;
                     data_wdata_o <= st_wdata;
                     off_q        <= ea[1:0];
                     type_q       <= lsu_type_i;
                     rd_q         <= rd_addr_i;
                  end
               end
            end
            REQ: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (data_rvalid_i) begin
                  state_q <= IDLE;
                  if (data_err_i) begin
                     lsu_err_o <= 1'b1;
                  end else if (!data_we_o) begin
                     wb_en_o   <= 1'b1;
                     wb_addr_o <= rd_q;
                     wb_data_o <= ld_result;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_milano_lsu.sv
// Directed testbench for milano_lsu with hand-computed expectations.
module tb_milano_lsu;
   import milano_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        lsu_req_i = 1'b0;
   logic        lsu_we_i = 1'b0;
   logic [2:0]  lsu_type_i = '0;
   logic [31:0] operand_a_i = '0;
   logic [31:0] operand_b_i = '0;
   logic [31:0] wdata_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        busy_o;
   logic        data_req_o;
   logic        data_gnt_i = 1'b0;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i = 1'b0;
   logic [31:0] data_rdata_i = '0;
   logic        data_err_i = 1'b0;
   logic        wb_en_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;
   logic        lsu_err_o;

   int total = 0;
   int bad = 0;

   milano_lsu #(.ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_type_i(lsu_type_i),
      .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .wdata_i(wdata_i),
      .rd_addr_i(rd_addr_i), .busy_o(busy_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
      .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
      .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o), .lsu_err_o(lsu_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic we, input logic [2:0] typ, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] wd, input logic [4:0] rd);
      lsu_req_i = 1'b1; lsu_we_i = we; lsu_type_i = typ;
      operand_a_i = a; operand_b_i = b; wdata_i = wd; rd_addr_i = rd;
      tick();
      lsu_req_i = 1'b0;
   endtask

   task automatic bus_chk(input string tag, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wd);
      check({tag, "_req"},   32'(data_req_o), 1);
      check({tag, "_addr"},  data_addr_o, addr);
      check({tag, "_we"},    32'(data_we_o), 32'(we));
      check({tag, "_be"},    32'(data_be_o), 32'(be));
      check({tag, "_wdata"}, data_wdata_o, wd);
      check({tag, "_busy"},  32'(busy_o), 1);
   endtask

   // Holds grant low for `hold` cycles (checking bus stability), then grants.
   task automatic grant(input string tag, input int unsigned hold, input logic [31:0] addr,
                        input logic we, input logic [3:0] be, input logic [31:0] wd);
      for (int unsigned i = 0; i < hold; i++) begin
         bus_chk(tag, addr, we, be, wd);
         tick();
      end
      bus_chk(tag, addr, we, be, wd);
      data_gnt_i = 1'b1;
      tick();
      data_gnt_i = 1'b0;
      check({tag, "_req_drop"}, 32'(data_req_o), 0);
   endtask

   task automatic respond(input string tag, input int unsigned gap, input logic [31:0] rdata,
                          input logic err, input logic exp_wb, input logic [31:0] exp_data,
                          input logic [4:0] exp_rd);
      for (int unsigned i = 0; i < gap; i++) begin
         check({tag, "_wait_busy"}, 32'(busy_o), 1);
         check({tag, "_wait_req"},  32'(data_req_o), 0);
         tick();
      end
      data_rvalid_i = 1'b1; data_rdata_i = rdata; data_err_i = err;
      tick();
      data_rvalid_i = 1'b0; data_err_i = 1'b0;
      check({tag, "_wb_en"}, 32'(wb_en_o), 32'(exp_wb));
      if (exp_wb) begin
         check({tag, "_wb_data"}, wb_data_o, exp_data);
         check({tag, "_wb_addr"}, 32'(wb_addr_o), 32'(exp_rd));
      end
      check({tag, "_err"},  32'(lsu_err_o), 32'(err));
      check({tag, "_busy"}, 32'(busy_o), 32'(lsu_req_i));
   endtask

   task automatic zero_chk(input string tag);
      check({tag, "_req"},   32'(data_req_o), 0);
      check({tag, "_addr"},  data_addr_o, 0);
      check({tag, "_we"},    32'(data_we_o), 0);
      check({tag, "_be"},    32'(data_be_o), 0);
      check({tag, "_wdata"}, data_wdata_o, 0);
      check({tag, "_wb_en"}, 32'(wb_en_o), 0);
      check({tag, "_wb_addr"}, 32'(wb_addr_o), 0);
      check({tag, "_wb_data"}, wb_data_o, 0);
      check({tag, "_err"},   32'(lsu_err_o), 0);
      check({tag, "_busy"},  32'(busy_o), 0);
   endtask

   initial begin
      tick();
      tick();
      zero_chk("rst");
      rst_i = 1'b0;
      tick();

      // LW 0x1000+4, grant at once, rvalid one WAIT cycle later
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_type_i = LSU_LW;
      operand_a_i = 32'h1000; operand_b_i = 32'h4; wdata_i = 32'h0; rd_addr_i = 5'd3;
      #1;
      check("lw_busy_comb", 32'(busy_o), 1);
      tick();
      lsu_req_i = 1'b0;
      grant("lw", 0, 32'h1004, 1'b0, 4'hF, 32'h0);
      respond("lw", 1, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 5'd3);
      tick();
      check("lw_wb_pulse", 32'(wb_en_o), 0);

      // LB at 0x1003, minimum latency (3 ticks request to writeback)
      issue(1'b0, LSU_LB, 32'h1000, 32'h3, 32'h000000A5, 5'd9);
      grant("lb", 0, 32'h1000, 1'b0, 4'b1000, 32'hA5A5A5A5);
      respond("lb", 0, 32'h80FF0000, 1'b0, 1'b1, 32'hFFFFFF80, 5'd9);

      // LBU accepted in the completion cycle of the LB
      issue(1'b0, LSU_LBU, 32'h1000, 32'h3, 32'h0, 5'd10);
      check("lbu_b2b_wb_drop", 32'(wb_en_o), 0);
      grant("lbu", 0, 32'h1000, 1'b0, 4'b1000, 32'h0);
      respond("lbu", 0, 32'h80FF0000, 1'b0, 1'b1, 32'h00000080, 5'd10);

      // SH 0x1234ABCD at 0x2002: no writeback
      issue(1'b1, LSU_LH, 32'h2000, 32'h2, 32'h1234ABCD, 5'd4);
      grant("sh", 0, 32'h2000, 1'b1, 4'b1100, 32'hABCDABCD);
      respond("sh", 1, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0, 5'd0);

      // LH at 0x3000-2 with grant withheld 5 cycles; stray rvalid in REQ ignored
      issue(1'b0, LSU_LH, 32'h3000, 32'hFFFFFFFE, 32'h55557777, 5'd12);
      for (int unsigned i = 0; i < 5; i++) begin
         bus_chk("hold", 32'h2FFC, 1'b0, 4'b1100, 32'h77777777);
         data_rvalid_i = (i == 2); data_err_i = (i == 2);
         tick();
         data_rvalid_i = 1'b0; data_err_i = 1'b0;
         check("hold_no_err", 32'(lsu_err_o), 0);
         check("hold_no_wb", 32'(wb_en_o), 0);
      end
      grant("hold", 0, 32'h2FFC, 1'b0, 4'b1100, 32'h77777777);
      respond("hold", 3, 32'h80010000, 1'b0, 1'b1, 32'hFFFF8001, 5'd12);

      // Load bus error
      issue(1'b0, LSU_LW, 32'h4000, 32'h0, 32'h0, 5'd5);
      grant("lerr", 0, 32'h4000, 1'b0, 4'hF, 32'h0);
      respond("lerr", 0, 32'h12345678, 1'b1, 1'b0, 32'h0, 5'd0);
      tick();
      check("lerr_pulse", 32'(lsu_err_o), 0);

`ifdef MILANO_LSU_MISALIGN_TRAP_EN
      issue(1'b0, LSU_LW, 32'h1000, 32'h1, 32'h0, 5'd6);
      check("mis_req", 32'(data_req_o), 0);
      check("mis_err", 32'(lsu_err_o), 1);
      check("mis_busy", 32'(busy_o), 0);
      tick();
      check("mis_req2", 32'(data_req_o), 0);
      check("mis_err_pulse", 32'(lsu_err_o), 0);
      check("mis_wb", 32'(wb_en_o), 0);
`else
      issue(1'b0, LSU_LW, 32'h1000, 32'h1, 32'h0, 5'd6);
      grant("mis", 0, 32'h1000, 1'b0, 4'hF, 32'h0);
      respond("mis", 0, 32'h11223344, 1'b0, 1'b1, 32'h11223344, 5'd6);
      issue(1'b0, LSU_LHU, 32'h1000, 32'h3, 32'h0, 5'd8);
      grant("mish", 0, 32'h1000, 1'b0, 4'b1100, 32'h0);
      respond("mish", 0, 32'hBEEF1234, 1'b0, 1'b1, 32'h0000BEEF, 5'd8);
`endif

      // Reset during WAIT, then a late rvalid must be ignored
      issue(1'b1, LSU_LB, 32'h5000, 32'h9, 32'h000000C3, 5'd7);
      grant("rw", 0, 32'h5008, 1'b1, 4'b0010, 32'hC3C3C3C3);
      rst_i = 1'b1;
      #1;
      zero_chk("rstw");
      tick();
      rst_i = 1'b0;
      data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFFFFFF;
      tick();
      data_rvalid_i = 1'b0;
      check("late_rv_wb", 32'(wb_en_o), 0);
      check("late_rv_busy", 32'(busy_o), 0);
      check("late_rv_req", 32'(data_req_o), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
